// File: rtl/pcie_tx_arb_pkg.sv
// rtl/pcie_tx_arb_pkg.sv - shared types for the PCIe TX Avalon-ST arbiter
package pcie_tx_arb_pkg;

    localparam int AVST_DATA_WIDTH  = 256;
    localparam int AVST_EMPTY_WIDTH = 2;

    typedef enum logic [1:0] {IDLE, GNT_CPL, GNT_DMA} t_arb_state;

    typedef enum bit {SRC_CPL, SRC_DMA} t_src;

    typedef struct packed {
        logic [AVST_DATA_WIDTH-1:0]  data;
        logic [AVST_EMPTY_WIDTH-1:0] empty;
        logic                        sop;
        logic                        eop;
    } t_avst_beat;

    function automatic t_arb_state grant_state(input t_src src);
        return (src == SRC_CPL) ? GNT_CPL : GNT_DMA;
    endfunction

endpackage

// File: rtl/avst_skid_buffer.sv
// rtl/avst_skid_buffer.sv - 2-entry registered skid buffer for an Avalon-ST beat stream
module avst_skid_buffer #(
    parameter int DATA_WIDTH  = 256,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int W = DATA_WIDTH + EMPTY_WIDTH + 2;

    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] in_beat;

    assign in_beat  = {in_data, in_empty, in_sop, in_eop};
    // Ready is a pure function of occupancy: the skid slot is the only thing that can block.
    assign in_ready = !skid_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_q     <= in_beat;
                main_valid <= in_valid;
            end
        end else if (in_valid && !skid_valid) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign {out_data, out_empty, out_sop, out_eop} = main_q;
    assign out_valid = main_valid;

endmodule

// File: rtl/pcie_tx_st_arbiter.sv
// rtl/pcie_tx_st_arbiter.sv - packet-boundary round-robin arbiter of CplD and DMA onto the HIP TX port
module pcie_tx_st_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int EMPTY_WIDTH = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  cpl_data,
    input  logic [EMPTY_WIDTH-1:0] cpl_empty,
    input  logic                   cpl_sop,
    input  logic                   cpl_eop,
    input  logic                   cpl_valid,
    output logic                   cpl_ready,
    input  logic [DATA_WIDTH-1:0]  dma_data,
    input  logic [EMPTY_WIDTH-1:0] dma_empty,
    input  logic                   dma_sop,
    input  logic                   dma_eop,
    input  logic                   dma_valid,
    output logic                   dma_ready,
    output logic [DATA_WIDTH-1:0]  tx_data,
    output logic [EMPTY_WIDTH-1:0] tx_empty,
    output logic                   tx_sop,
    output logic                   tx_eop,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [CNT_WIDTH-1:0]   cnt_cpl_pkts,
    output logic [CNT_WIDTH-1:0]   cnt_dma_pkts,
    output logic                   err_protocol
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    t_arb_state state;
    t_src       last_grant;
    logic       sel_cpl, sel_dma, drain_cpl, drain_dma;
    logic       buf_valid, buf_ready, accept;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic [EMPTY_WIDTH-1:0] buf_empty;
    logic       buf_sop, buf_eop;

    // Grant is combinational in IDLE so a new packet's first beat needs no bubble.
    always_comb begin
        sel_cpl   = 1'b0;
        sel_dma   = 1'b0;
        drain_cpl = 1'b0;
        drain_dma = 1'b0;
        case (state)
            IDLE: begin
                if (cpl_valid && cpl_sop && (!(dma_valid && dma_sop) || last_grant == SRC_DMA))
                    sel_cpl = 1'b1;
                else if (dma_valid && dma_sop)
                    sel_dma = 1'b1;
                else begin
                    drain_cpl = cpl_valid;
                    drain_dma = dma_valid;
                end
            end
            GNT_CPL: sel_cpl = 1'b1;
            GNT_DMA: sel_dma = 1'b1;
            default: ;
        endcase
    end

    assign buf_valid = (sel_cpl && cpl_valid) || (sel_dma && dma_valid);
    assign buf_data  = sel_dma ? dma_data  : cpl_data;
    assign buf_empty = sel_dma ? dma_empty : cpl_empty;
    assign buf_sop   = sel_dma ? dma_sop   : cpl_sop;
    assign buf_eop   = sel_dma ? dma_eop   : cpl_eop;
    assign accept    = buf_valid && buf_ready && !reset;

    assign cpl_ready = !reset && ((sel_cpl && buf_ready) || drain_cpl);
    assign dma_ready = !reset && ((sel_dma && buf_ready) || drain_dma);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= SRC_DMA;
            cnt_cpl_pkts <= '0;
            cnt_dma_pkts <= '0;
            err_protocol <= 1'b0;
        end else begin
            if (drain_cpl || drain_dma)
                err_protocol <= 1'b1;
            if (accept && buf_eop) begin
                if (sel_cpl)
                    cnt_cpl_pkts <= cnt_cpl_pkts + CNT_ONE;
                else
                    cnt_dma_pkts <= cnt_dma_pkts + CNT_ONE;
            end
            if (accept) begin
                if (state == IDLE) begin
                    last_grant <= sel_cpl ? SRC_CPL : SRC_DMA;
                    state      <= buf_eop ? IDLE : grant_state(sel_cpl ? SRC_CPL : SRC_DMA);
                end else begin
                    // A sop inside a granted packet is flagged but forwarded as-is.
                    if (buf_sop)
                        err_protocol <= 1'b1;
                    if (buf_eop)
                        state <= IDLE;
                end
            end
        end
    end

    avst_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .EMPTY_WIDTH(EMPTY_WIDTH)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .in_data  (buf_data),
        .in_empty (buf_empty),
        .in_sop   (buf_sop),
        .in_eop   (buf_eop),
        .in_valid (buf_valid),
        .in_ready (buf_ready),
        .out_data (tx_data),
        .out_empty(tx_empty),
        .out_sop  (tx_sop),
        .out_eop  (tx_eop),
        .out_valid(tx_valid),
        .out_ready(tx_ready)
    );

endmodule

// File: tb/tb_pcie_tx_st_arbiter.sv
// tb/tb_pcie_tx_st_arbiter.sv - randomized self-checking bench with a packet-level reference model
module tb_pcie_tx_st_arbiter;
    import pcie_tx_arb_pkg::*;

    localparam int DW = 256;
    localparam int EW = 2;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cpl_data, dma_data, tx_data;
    logic [EW-1:0] cpl_empty, dma_empty, tx_empty;
    logic          cpl_sop, cpl_eop, cpl_valid, cpl_ready;
    logic          dma_sop, dma_eop, dma_valid, dma_ready;
    logic          tx_sop, tx_eop, tx_valid, tx_ready;
    logic [CW-1:0] cnt_cpl_pkts, cnt_dma_pkts;
    logic          err_protocol;

    always #5 clock = ~clock;

    pcie_tx_st_arbiter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .cpl_data(cpl_data), .cpl_empty(cpl_empty), .cpl_sop(cpl_sop), .cpl_eop(cpl_eop),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .dma_data(dma_data), .dma_empty(dma_empty), .dma_sop(dma_sop), .dma_eop(dma_eop),
        .dma_valid(dma_valid), .dma_ready(dma_ready),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cnt_cpl_pkts(cnt_cpl_pkts), .cnt_dma_pkts(cnt_dma_pkts), .err_protocol(err_protocol)
    );

    int checks = 0;
    int errors = 0;

    // Upstream packet sources and the tx-side log.
    t_avst_beat    cpl_q[$];
    t_avst_beat    dma_q[$];
    logic [DW-1:0] tx_log[$];
    int cpl_pct = 100, dma_pct = 100, rdy_pct = 100;
    bit cpl_take, dma_take;
    int dma_acc_cnt;

    // Reference model: packet owner, last winner, in-flight beats, counters, sticky error.
    int            m_owner = 0;
    int            m_last  = 2;
    t_avst_beat    m_q[$];
    logic [CW-1:0] m_cnt_c = '0, m_cnt_d = '0;
    bit            m_err = 1'b0;
    bit            e_rc, e_rd, e_drain;
    t_avst_beat    s_cpl, s_dma;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] tag, input logic [15:0] idx);
        return {8{tag, idx}};
    endfunction

    task automatic add_pkt(input int src, input int n, input logic [15:0] tag);
        t_avst_beat b;
        for (int i = 0; i < n; i++) begin
            b.data  = mk(tag, 16'(i));
            b.empty = (i == n - 1) ? 2'($urandom_range(3)) : 2'd0;
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            if (src == 1) cpl_q.push_back(b); else dma_q.push_back(b);
        end
    endtask

    task automatic drive_inputs();
        cpl_valid = (cpl_q.size() > 0) && ($urandom_range(99) < cpl_pct);
        dma_valid = (dma_q.size() > 0) && ($urandom_range(99) < dma_pct);
        {cpl_data, cpl_empty, cpl_sop, cpl_eop} = (cpl_q.size() > 0) ? cpl_q[0] : '0;
        {dma_data, dma_empty, dma_sop, dma_eop} = (dma_q.size() > 0) ? dma_q[0] : '0;
        tx_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic model_expect();
        bit in_rdy, cc, cd;
        int win;
        in_rdy  = (m_q.size() < 2);
        e_rc    = 1'b0;
        e_rd    = 1'b0;
        e_drain = 1'b0;
        win     = 0;
        s_cpl   = {cpl_data, cpl_empty, cpl_sop, cpl_eop};
        s_dma   = {dma_data, dma_empty, dma_sop, dma_eop};
        if (!reset) begin
            if (m_owner == 1) e_rc = in_rdy;
            else if (m_owner == 2) e_rd = in_rdy;
            else begin
                cc = cpl_valid && cpl_sop;
                cd = dma_valid && dma_sop;
                if (cc && cd) win = (m_last == 2) ? 1 : 2;
                else if (cc) win = 1;
                else if (cd) win = 2;
                if (win == 1) e_rc = in_rdy;
                else if (win == 2) e_rd = in_rdy;
                else begin
                    e_rc    = cpl_valid;
                    e_rd    = dma_valid;
                    e_drain = 1'b1;
                end
            end
        end
    endtask

    task automatic model_take(input int src, input t_avst_beat b);
        m_q.push_back(b);
        if (b.eop) begin
            if (src == 1) m_cnt_c++; else m_cnt_d++;
        end
        if (m_owner == 0) begin
            m_last  = src;
            m_owner = b.eop ? 0 : src;
        end else begin
            if (b.sop) m_err = 1'b1;
            if (b.eop) m_owner = 0;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_owner = 0;
            m_last  = 2;
            m_q.delete();
            m_cnt_c = '0;
            m_cnt_d = '0;
            m_err   = 1'b0;
        end else begin
            if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
            if (e_drain) begin
                if (e_rc || e_rd) m_err = 1'b1;
            end else begin
                if (cpl_valid && e_rc) model_take(1, s_cpl);
                if (dma_valid && e_rd) model_take(2, s_dma);
            end
        end
    endtask

    task automatic compare();
        chk("tx_valid", tx_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("tx_data", tx_data, m_q[0].data);
            chk("tx_framing", {tx_empty, tx_sop, tx_eop}, {m_q[0].empty, m_q[0].sop, m_q[0].eop});
        end
        chk("cpl_ready", cpl_ready, e_rc);
        chk("dma_ready", dma_ready, e_rd);
        chk("cnt_cpl_pkts", cnt_cpl_pkts, m_cnt_c);
        chk("cnt_dma_pkts", cnt_dma_pkts, m_cnt_d);
        chk("err_protocol", err_protocol, m_err);
    endtask

    task automatic cycle();
        @(negedge clock);
        model_expect();
        compare();
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        cpl_take = cpl_valid && cpl_ready;
        dma_take = dma_valid && dma_ready;
        @(posedge clock);
        model_commit();
        if (cpl_take && cpl_q.size() > 0) void'(cpl_q.pop_front());
        if (dma_take && dma_q.size() > 0) begin
            void'(dma_q.pop_front());
            dma_acc_cnt++;
        end
        #1 drive_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpl_q.delete();
        dma_q.delete();
        drive_inputs();
        cycle();
        reset = 1'b0;
        tx_log.delete();
        dma_acc_cnt = 0;
    endtask

    task automatic drain_all(input string name, input int max);
        int n = 0;
        while ((cpl_q.size() > 0 || dma_q.size() > 0 || m_q.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        cycle();
        chk({name, "_timeout"}, n < max, 1'b1);
    endtask

    function automatic logic [DW-1:0] words(input int base);
        logic [DW-1:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(base + k);
        return d;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t_avst_beat b;
        int         ncpl, ndma, wbase, nbeats, n;
        drive_inputs();
        cycle();
        do_reset();
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_cnt_cpl", cnt_cpl_pkts, '0);
        chk("rst_cnt_dma", cnt_dma_pkts, '0);
        chk("rst_err", err_protocol, 1'b0);
        chk("rst_readies", {cpl_ready, dma_ready}, 2'b00);

        // Single-beat CplD with empty=2.
        b = '{data: mk(16'hC001, 16'h0), empty: 2'd2, sop: 1'b1, eop: 1'b1};
        cpl_q.push_back(b);
        drive_inputs();
        #1 chk("t1_cpl_ready", cpl_ready, 1'b1);
        cycle();
        chk("t1_tx_valid", tx_valid, 1'b1);
        chk("t1_tx_data", tx_data, mk(16'hC001, 16'h0));
        chk("t1_tx_frame", {tx_empty, tx_sop, tx_eop}, 4'b1011);
        chk("t1_cnt_cpl", cnt_cpl_pkts, 32'd1);
        drain_all("t1", 50);

        // Simultaneous sop after reset: CPL first, then the whole DMA packet; next tie to CPL.
        do_reset();
        add_pkt(1, 1, 16'hC002);
        add_pkt(2, 4, 16'hD002);
        drive_inputs();
        drain_all("t2a", 50);
        add_pkt(1, 1, 16'hC003);
        add_pkt(2, 1, 16'hD003);
        drive_inputs();
        drain_all("t2b", 50);
        chk("t2_log_size", tx_log.size(), 7);
        if (tx_log.size() == 7) begin
            chk("t2_first_cpl", tx_log[0], mk(16'hC002, 16'h0));
            for (int i = 0; i < 4; i++) chk("t2_dma_beat", tx_log[1+i], mk(16'hD002, 16'(i)));
            chk("t2_tie_cpl", tx_log[5], mk(16'hC003, 16'h0));
            chk("t2_tie_dma", tx_log[6], mk(16'hD003, 16'h0));
        end

        // CPL arrives while a 9-beat DMA packet is in flight.
        do_reset();
        add_pkt(2, 9, 16'hD004);
        drive_inputs();
        n = 0;
        while (dma_acc_cnt < 2 && n < 50) begin cycle(); n++; end
        chk("t3_wait", n < 50, 1'b1);
        add_pkt(1, 1, 16'hC004);
        drive_inputs();
        drain_all("t3", 100);
        chk("t3_log_size", tx_log.size(), 10);
        if (tx_log.size() == 10) begin
            for (int i = 0; i < 9; i++) chk("t3_dma_beat", tx_log[i], mk(16'hD004, 16'(i)));
            chk("t3_cpl_after", tx_log[9], mk(16'hC004, 16'h0));
        end

        // 16 DMA packets of incrementing words, tx_ready at 70%.
        do_reset();
        rdy_pct = 70;
        dma_pct = 85;
        wbase = 0;
        nbeats = 0;
        for (int p = 0; p < 16; p++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = '{data: words(wbase), empty: 2'd0, sop: (i == 0), eop: (i == n - 1)};
                dma_q.push_back(b);
                wbase += 16;
                nbeats++;
            end
        end
        drive_inputs();
        drain_all("t4", 2000);
        chk("t4_beats", tx_log.size(), nbeats);
        for (int i = 0; i < tx_log.size(); i++) chk("t4_payload", tx_log[i], words(16 * i));
        chk("t4_cnt_dma", cnt_dma_pkts, 32'd16);
        rdy_pct = 100;
        dma_pct = 100;

        // Mid-packet beat in IDLE with no competing sop is drained and flagged.
        do_reset();
        b = '{data: mk(16'hDEAD, 16'h0), empty: 2'd0, sop: 1'b0, eop: 1'b1};
        dma_q.push_back(b);
        drive_inputs();
        #1 chk("t5_dma_ready", dma_ready, 1'b1);
        cycle();
        chk("t5_err", err_protocol, 1'b1);
        chk("t5_tx_valid", tx_valid, 1'b0);
        chk("t5_cnt_dma", cnt_dma_pkts, 32'd0);
        drain_all("t5", 20);
        chk("t5_no_tx", tx_log.size(), 0);

        // Reset pulse while beat 2 of a DMA packet is presented.
        do_reset();
        add_pkt(2, 4, 16'hD006);
        drive_inputs();
        n = 0;
        while (dma_acc_cnt < 1 && n < 50) begin cycle(); n++; end
        reset = 1'b1;
        cpl_q.delete();
        dma_q.delete();
        drive_inputs();
        cycle();
        reset = 1'b0;
        chk("t6_tx_valid", tx_valid, 1'b0);
        chk("t6_cnts", {cnt_cpl_pkts, cnt_dma_pkts}, 64'd0);
        add_pkt(1, 1, 16'hC006);
        drive_inputs();
        #1 chk("t6_cpl_ready", cpl_ready, 1'b1);
        cycle();
        chk("t6_tx_cpl", tx_data, mk(16'hC006, 16'h0));
        chk("t6_cnt_cpl", cnt_cpl_pkts, 32'd1);
        drain_all("t6", 20);

        // Randomized mix of both sources under random backpressure.
        do_reset();
        rdy_pct = 60;
        cpl_pct = 70;
        dma_pct = 70;
        ncpl = 0;
        ndma = 0;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(1) == 0) begin
                add_pkt(1, $urandom_range(1, 3), 16'(16'hA000 + p));
                ncpl++;
            end else begin
                add_pkt(2, $urandom_range(1, 6), 16'(16'hB000 + p));
                ndma++;
            end
        end
        drive_inputs();
        drain_all("t7", 5000);
        chk("t7_cnt_cpl", cnt_cpl_pkts, 32'(ncpl));
        chk("t7_cnt_dma", cnt_dma_pkts, 32'(ndma));
        chk("t7_err", err_protocol, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
